// File: rtl/comparison_sequencer.sv
// rtl/comparison_sequencer.sv - load-button sequencer feeding the 4-bit comparison unit
module comparison_sequencer #(
    parameter int SETTLE = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       load,
    input  logic [3:0] data_in,
    input  logic [1:0] op,
    input  logic [3:0] cmp_result,
    output logic [7:0] z,
    output logic [1:0] select,
    output logic [3:0] result,
    output logic       valid,
    output logic       busy
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT_Y = 2'd1,
        S_SETTLE = 2'd2,
        S_SHOW   = 2'd3
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(SETTLE - 1);

    state_t     state_q, state_d;
    logic       load_q, load_d;
    logic [3:0] x_q, x_d;
    logic [3:0] y_q, y_d;
    logic [1:0] sel_q, sel_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] result_q, result_d;
    logic       ld;

    assign ld     = load & ~load_q;
    assign load_d = load;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            load_q   <= 1'b0;
            x_q      <= 4'h0;
            y_q      <= 4'h0;
            sel_q    <= 2'b00;
            cnt_q    <= 4'h0;
            result_q <= 4'h0;
        end else begin
            state_q  <= state_d;
            load_q   <= load_d;
            x_q      <= x_d;
            y_q      <= y_d;
            sel_q    <= sel_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (ld) state_d = S_WAIT_Y;
            S_WAIT_Y: if (ld) state_d = S_SETTLE;
            S_SETTLE: if (cnt_q == 4'h0) state_d = S_SHOW;
            S_SHOW:   if (ld) state_d = S_WAIT_Y;
            default:  state_d = S_IDLE;
        endcase
    end

    // Datapath loads follow the same decode; ld during the settle wait is dropped.
    always_comb begin
        x_d      = x_q;
        y_d      = y_q;
        sel_d    = sel_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        case (state_q)
            S_IDLE, S_SHOW: begin
                if (ld) x_d = data_in;
            end
            S_WAIT_Y: begin
                if (ld) begin
                    y_d   = data_in;
                    sel_d = op;
                    cnt_d = CNT_INIT;
                end
            end
            S_SETTLE: begin
                if (cnt_q == 4'h0) result_d = cmp_result;
                else               cnt_d    = cnt_q - 4'h1;
            end
            default: ;
        endcase
    end

    always_comb begin
        z      = {x_q, y_q};
        select = sel_q;
        result = result_q;
        valid  = (state_q == S_SHOW);
        busy   = (state_q == S_SETTLE);
    end

endmodule

// File: tb/tb_comparison_sequencer.sv
// tb/tb_comparison_sequencer.sv - randomized and directed checks of three settle-interval builds
module tb_comparison_sequencer;

    logic       clk;
    logic       reset_n;
    logic       load;
    logic [3:0] data_in;
    logic [1:0] op;
    logic       ovr_en;
    logic [3:0] ovr_val;

    logic [7:0] zo  [3];
    logic [1:0] so  [3];
    logic [3:0] ro  [3];
    logic       vo  [3];
    logic       bo  [3];
    logic [3:0] cmp [3];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    logic pl  = 1'b0;

    int         mode [3];
    int         dl   [3];
    logic [3:0] mx   [3];
    logic [3:0] my   [3];
    logic [3:0] mres [3];
    logic [1:0] msel [3];
    int         sval [3] = '{2, 1, 15};

    function automatic logic [3:0] ref_cmp(input logic [3:0] a, input logic [3:0] b, input logic [1:0] o);
        case (o)
            2'd0:    return {3'b000, a == b};
            2'd1:    return {3'b000, a > b};
            2'd2:    return {3'b000, a < b};
            default: return a ^ b;
        endcase
    endfunction

    always_comb for (int i = 0; i < 3; i++)
        cmp[i] = ovr_en ? ovr_val : ref_cmp(zo[i][7:4], zo[i][3:0], so[i]);

    comparison_sequencer #(.SETTLE(2)) dut0 (
        .clk(clk), .reset_n(reset_n), .load(load), .data_in(data_in), .op(op),
        .cmp_result(cmp[0]), .z(zo[0]), .select(so[0]), .result(ro[0]), .valid(vo[0]), .busy(bo[0]));
    comparison_sequencer #(.SETTLE(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .load(load), .data_in(data_in), .op(op),
        .cmp_result(cmp[1]), .z(zo[1]), .select(so[1]), .result(ro[1]), .valid(vo[1]), .busy(bo[1]));
    comparison_sequencer #(.SETTLE(15)) dut2 (
        .clk(clk), .reset_n(reset_n), .load(load), .data_in(data_in), .op(op),
        .cmp_result(cmp[2]), .z(zo[2]), .select(so[2]), .result(ro[2]), .valid(vo[2]), .busy(bo[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        pl = 1'b0;
        for (int i = 0; i < 3; i++) begin
            mode[i] = 0; dl[i] = 0;
            mx[i] = 4'h0; my[i] = 4'h0; mres[i] = 4'h0; msel[i] = 2'b00;
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("z%0d@%0d", i, cyc), int'(zo[i]), int'({mx[i], my[i]}));
            chk($sformatf("select%0d@%0d", i, cyc), int'(so[i]), int'(msel[i]));
            chk($sformatf("result%0d@%0d", i, cyc), int'(ro[i]), int'(mres[i]));
            chk($sformatf("valid%0d@%0d", i, cyc), int'(vo[i]), int'(mode[i] == 3));
            chk($sformatf("busy%0d@%0d", i, cyc), int'(bo[i]), int'(mode[i] == 2));
        end
    endtask

    // Transaction-level reference: a Y press schedules the capture at an absolute edge number.
    task automatic tick();
        logic       ld;
        logic [3:0] cv;
        int         e;
        ld = load & ~pl;
        e  = cyc + 1;
        for (int i = 0; i < 3; i++) begin
            cv = ovr_en ? ovr_val : ref_cmp(mx[i], my[i], msel[i]);
            if (mode[i] == 2) begin
                if (e == dl[i]) begin mres[i] = cv; mode[i] = 3; end
            end else if (ld) begin
                if (mode[i] == 1) begin
                    my[i] = data_in; msel[i] = op; dl[i] = e + sval[i]; mode[i] = 2;
                end else begin
                    mx[i] = data_in; mode[i] = 1;
                end
            end
        end
        pl  = load;
        cyc = e;
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic press(input logic [3:0] d, input logic [1:0] o);
        load = 1'b1; data_in = d; op = o;
        tick();
        load = 1'b0; data_in = 4'($urandom); op = 2'($urandom);
        tick();
    endtask

    initial begin
        reset_n = 1'b0; load = 1'b0; data_in = 4'h0; op = 2'b00;
        ovr_en = 1'b0; ovr_val = 4'h0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        #2 reset_n = 1'b1;
        tick();

        press(4'h9, 2'b01);
        press(4'h5, 2'b01);
        chk("z95", int'(zo[0]), 8'h95);
        chk("sel01", int'(so[0]), 2'b01);
        chk("busy_after_y", int'(bo[0]), 1);
        repeat (20) tick();
        chk("result_95", int'(ro[0]), 4'h1);
        chk("valid_95", int'(vo[0]), 1);

        load = 1'b1; data_in = 4'h3; op = 2'b10;
        tick();
        repeat (9) begin data_in = 4'($urandom); op = 2'($urandom); tick(); end
        chk("hold_x3", int'(zo[0]), 8'h35);
        chk("hold_valid_drop", int'(vo[0]), 0);
        load = 1'b0;
        tick();
        press(4'h7, 2'b10);
        press(4'hF, 2'b00);
        chk("settle_ignore_s2", int'(zo[0]), 8'h37);
        chk("settle_ignore_s15", int'(zo[2]), 8'h37);
        chk("show_accept_s1", int'(zo[1]), 8'hF7);
        repeat (20) tick();
        chk("result_37", int'(ro[0]), 4'h1);

        ovr_en = 1'b1; ovr_val = 4'hA;
        press(4'h2, 2'b00);
        press(4'h6, 2'b11);
        ovr_val = 4'h3;
        tick();
        chk("late_cmp", int'(ro[0]), 4'h3);
        repeat (4) tick();

        #2 reset_n = 1'b0;
        #1;
        model_reset();
        check_all();
        chk("reset_busy15", int'(bo[2]), 0);
        #2 reset_n = 1'b1;
        ovr_en = 1'b0;
        tick();

        for (int n = 0; n < 600; n++) begin
            load    = ($urandom_range(0, 2) == 0);
            data_in = 4'($urandom);
            op      = 2'($urandom);
            ovr_en  = ($urandom_range(0, 7) == 0);
            ovr_val = 4'($urandom);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
